// File: rtl/jk_excitation_gen.sv
// Drives an external master-slave JK flip-flop so its q follows a serialized
// pattern word, and checks the fed-back q with a saturating mismatch count.
module jk_excitation_gen #(
  parameter int W          = 8,
  parameter int CHK_LAT    = 2,
  parameter int USE_TOGGLE = 0,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W-1:0]     s_data,
  input  logic             q_fb,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam int CW = (CHK_LAT > 2) ? $clog2(CHK_LAT) : 1;
  localparam logic [IW-1:0] LAST  = IW'(W - 1);
  localparam logic [CW-1:0] WLOAD = CW'(CHK_LAT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [W-1:0]     word_q;
  logic [IW-1:0]    idx_q;
  logic [IW-1:0]    nidx_d;
  logic [CW-1:0]    wcnt_q;
  logic             exp_q;
  logic             cleared_q;
  logic             clr_ph_q;
  logic             j_q;
  logic             k_q;
  logic             done_q;
  logic             mis_q;
  logic [ERR_W-1:0] err_q;

  function automatic logic [1:0] exc(input logic e, input logic t);
    if (e == t) return 2'b00;
    if (USE_TOGGLE != 0) return 2'b11;
    return t ? 2'b10 : 2'b01;
  endfunction

  assign nidx_d = idx_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      word_q    <= '0;
      idx_q     <= '0;
      wcnt_q    <= '0;
      exp_q     <= 1'b0;
      cleared_q <= 1'b0;
      clr_ph_q  <= 1'b0;
      j_q       <= 1'b0;
      k_q       <= 1'b0;
      done_q    <= 1'b0;
      mis_q     <= 1'b0;
      err_q     <= '0;
    end else begin
      j_q    <= 1'b0;
      k_q    <= 1'b0;
      done_q <= 1'b0;
      mis_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (s_valid) begin
            word_q <= s_data;
            idx_q  <= '0;
            if (!cleared_q) begin
              state_q  <= S_CLEAR;
              clr_ph_q <= 1'b1;
              k_q      <= 1'b1;
            end else begin
              state_q    <= S_DRIVE;
              {j_q, k_q} <= exc(exp_q, s_data[0]);
            end
          end
        end
        S_CLEAR: begin
          state_q <= S_WAIT;
          wcnt_q  <= WLOAD;
        end
        S_DRIVE: begin
          exp_q   <= word_q[idx_q];
          state_q <= S_WAIT;
          wcnt_q  <= WLOAD;
        end
        S_WAIT: begin
          if (wcnt_q == '0) state_q <= S_CHECK;
          else wcnt_q <= wcnt_q - 1'b1;
        end
        S_CHECK: begin
          // After any check the real FF state is the best predictor.
          exp_q <= q_fb;
          if (q_fb != exp_q) begin
            mis_q <= 1'b1;
            if (~&err_q) err_q <= err_q + 1'b1;
          end
          if (clr_ph_q) begin
            clr_ph_q   <= 1'b0;
            cleared_q  <= 1'b1;
            state_q    <= S_DRIVE;
            {j_q, k_q} <= exc(q_fb, word_q[0]);
          end else if (idx_q == LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            idx_q      <= nidx_d;
            state_q    <= S_DRIVE;
            {j_q, k_q} <= exc(q_fb, word_q[nidx_d]);
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign s_ready  = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign j        = j_q;
  assign k        = k_q;
  assign done     = done_q;
  assign mismatch = mis_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_jk_excitation_gen.sv
// Bench for jk_excitation_gen: two instances (set/reset and toggle flavours)
// each driving a behavioural master-slave JK flip-flop.
module tb_jk_excitation_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  int         fb_mode = 0;
  bit         sel = 1'b0;

  logic       rdy0, j0, k0, busy0, done0, mis0, qfb0;
  logic       rdy1, j1, k1, busy1, done1, mis1, qfb1;
  logic [7:0] err0;
  logic [1:0] err1;

  logic q0 = 1'b1, m0 = 1'b1;
  logic q1 = 1'b1, m1 = 1'b1;

  int nvec = 0;
  int nerr = 0;

  logic [1:0] pairq[$];
  bit         misq[$];
  bit         em;
  int         err_m;

  always #5 clk = ~clk;

  jk_excitation_gen #(.W(8), .CHK_LAT(2), .USE_TOGGLE(0), .ERR_W(8)) u0 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy0),
    .s_data(s_data), .q_fb(qfb0), .j(j0), .k(k0), .busy(busy0),
    .done(done0), .mismatch(mis0), .err_cnt(err0)
  );

  jk_excitation_gen #(.W(8), .CHK_LAT(2), .USE_TOGGLE(1), .ERR_W(2)) u1 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy1),
    .s_data(s_data), .q_fb(qfb1), .j(j1), .k(k1), .busy(busy1),
    .done(done1), .mismatch(mis1), .err_cnt(err1)
  );

  function automatic logic ff_next(logic jj, logic kk, logic qq);
    case ({jj, kk})
      2'b00: return qq;
      2'b01: return 1'b0;
      2'b10: return 1'b1;
      default: return ~qq;
    endcase
  endfunction

  // master on rising edge, slave on falling edge
  always @(posedge clk) begin
    m0 <= ff_next(j0, k0, q0);
    m1 <= ff_next(j1, k1, q1);
  end
  always @(negedge clk) begin
    q0 <= m0;
    q1 <= m1;
  end

  assign qfb0 = (fb_mode == 0) ? q0 : (fb_mode == 2);
  assign qfb1 = (fb_mode == 0) ? q1 : (fb_mode == 2);

  wire       rdy_w  = sel ? rdy1 : rdy0;
  wire       busy_w = sel ? busy1 : busy0;
  wire       done_w = sel ? done1 : done0;
  wire       mis_w  = sel ? mis1 : mis0;
  wire [1:0] jk_w   = sel ? {j1, k1} : {j0, k0};
  wire [7:0] err_w  = sel ? {6'b0, err1} : err0;
  wire       qff_w  = sel ? q1 : q0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] jk_exp(bit e, bit t, bit tog);
    if (e == t) return 2'b00;
    if (tog) return 2'b11;
    return t ? 2'b10 : 2'b01;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_jk", {j0, k0, j1, k1}, 4'b0000);
    chk("rst_ready", {rdy0, rdy1}, 2'b11);
    chk("rst_busy", {busy0, busy1}, 2'b00);
    chk("rst_done_mis", {done0, mis0, done1, mis1}, 4'b0000);
    chk("rst_err", {err0, err1}, 10'd0);
    @(negedge clk);
    rst = 1'b0;
    em = 1'b0;
    err_m = 0;
    pairq.delete();
    misq.delete();
  endtask

  task automatic push_check(bit t_exp, bit actual);
    bit mm;
    mm = (actual != t_exp);
    misq.push_back(mm);
    if (mm && err_m != (sel ? 3 : 255)) err_m++;
    em = actual;
  endtask

  // Called at a falling edge; returns at the first IDLE falling edge.
  task automatic run_word(input logic [7:0] w, input bit clr, input bit noise);
    int n;
    bit t, act, mm;
    logic [1:0] pr;
    if (clr) begin
      pairq.push_back(2'b01);
      push_check(1'b0, fb_mode == 2);
    end
    for (int b = 0; b < 8; b++) begin
      t = w[b];
      pairq.push_back(jk_exp(em, t, sel));
      act = (fb_mode == 0) ? t : (fb_mode == 2);
      push_check(t, act);
    end
    n = (clr ? 3 : 0) + 3 * 8 + 1;
    s_valid = 1'b1;
    s_data = w;
    chk("ready_in", rdy_w, 1);
    @(posedge clk);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (noise) s_data = 8'($urandom);
      else s_valid = 1'b0;
      if (c % 3 == 1 && pairq.size() > 0) pr = pairq.pop_front();
      else pr = 2'b00;
      chk("jk", jk_w, pr);
      if (c % 3 == 1 && c >= 4 && misq.size() > 0) mm = misq.pop_front();
      else mm = 1'b0;
      chk("mismatch", mis_w, mm);
      chk("done", done_w, c == n);
      chk("busy", busy_w, 1);
      chk("ready_busy", rdy_w, 0);
    end
    @(negedge clk);
    chk("ready_out", rdy_w, 1);
    chk("busy_out", busy_w, 0);
    chk("err_cnt", err_w, err_m);
    chk("queues_empty", pairq.size() + misq.size(), 0);
    if (fb_mode == 0) chk("ff_q", qff_w, w[7]);
    s_valid = 1'b0;
  endtask

  initial begin
    // 1: set/reset excitation, ideal FF
    sel = 1'b0; fb_mode = 0;
    do_reset();
    run_word(8'hA5, 1'b1, 1'b0);

    // 2: toggle excitation, back-to-back, second word skips CLEAR
    sel = 1'b1; fb_mode = 0;
    do_reset();
    run_word(8'h0F, 1'b1, 1'b0);
    run_word(8'hF0, 1'b0, 1'b0);

    // 3: q stuck low
    sel = 1'b0; fb_mode = 1;
    do_reset();
    run_word(8'hFF, 1'b1, 1'b0);
    chk("err_stuck0", err0, 8);

    // 4: q stuck high, 2-bit counter saturates
    sel = 1'b1; fb_mode = 2;
    do_reset();
    run_word(8'h00, 1'b1, 1'b0);
    chk("err_sat", err1, 3);

    // 5: s_valid held with noisy data while busy
    sel = 1'b0; fb_mode = 0;
    do_reset();
    run_word(8'h3C, 1'b1, 1'b1);
    run_word(8'hC3, 1'b0, 1'b0);

    // 6: reset in the middle of a word
    s_valid = 1'b1;
    s_data = 8'h5A;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      s_valid = 1'b0;
    end
    chk("mid_busy", busy0, 1);
    rst = 1'b1;
    #1;
    chk("abort_jk", {j0, k0}, 2'b00);
    chk("abort_ready", rdy0, 1);
    chk("abort_busy", busy0, 0);
    chk("abort_err", err0, 0);
    @(negedge clk);
    rst = 1'b0;
    em = 1'b0;
    err_m = 0;
    pairq.delete();
    misq.delete();
    run_word(8'h5A, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
